// File: rtl/cv32e40p_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_pkg
//   Shared types and constants for the instruction fetch front end.
//   fetch_state_e    : request-side FSM states of the fetch FIFO controller
//   FETCH_WORD_BYTES : byte stride between consecutive fetch addresses
//   word_align()     : forces an address onto a 32-bit word boundary
// ---------------------------------------------------------------------------
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        BRANCH_WAIT = 2'd2
    } fetch_state_e;

    localparam int unsigned FETCH_WORD_BYTES = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cv32e40p_fetch_fifo.sv
// ---------------------------------------------------------------------------
// cv32e40p_fetch_fifo
//   Synchronous first-word-fall-through FIFO for fetched instruction words.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset (pointers/count only)
//     push, wdata : write request and data
//     pop         : consume the head entry
//     flush       : drop all entries (wins over push/pop in the same cycle)
//     rdata       : head entry (undefined while empty)
//     count       : number of valid entries
//     empty, full : occupancy flags
//   A push while full is accepted only together with a pop.
// ---------------------------------------------------------------------------
module cv32e40p_fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr_q] <= wdata;
    end

endmodule

// File: rtl/cv32e40p_fetch_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// cv32e40p_fetch_fifo_ctrl
//   Upstream feeder of the IF-stage aligner. Issues word-aligned OBI
//   instruction fetches, tracks outstanding transactions, drops responses
//   made stale by a branch and buffers returned words in a small FIFO.
//   Ports:
//     clk, rst_n               : clock, asynchronous active-low reset
//     req_i                    : fetch enable from the controller
//     branch_i, branch_addr_i  : single-cycle redirect and its target
//     fetch_valid_o/ready_i    : FIFO head handshake towards the aligner
//     fetch_rdata_o, fetch_err_o : FIFO head word and its bus-error flag
//     instr_req_o, instr_addr_o, instr_gnt_i : OBI address phase
//     instr_rvalid_i, instr_rdata_i, instr_err_i : OBI response phase
//     busy_o                   : request pending or transactions in flight
//   Parameters:
//     DEPTH           : FIFO entries and credit limit (outstanding+buffered)
//     MAX_OUTSTANDING : limit on granted-but-unanswered transactions
// ---------------------------------------------------------------------------
module cv32e40p_fetch_fifo_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_e     state_q;
    logic [31:0]      next_addr_q;
    logic [31:0]      addr_q;
    logic [31:0]      branch_addr_q;
    logic [OUT_W-1:0] outstanding_q;
    logic [OUT_W-1:0] outstanding_d;
    logic [OUT_W-1:0] discard_q;
    logic [OUT_W-1:0] discard_d;

    logic [31:0]      branch_target;
    logic             credit_ok;
    logic             gnt;
    logic             stale_gnt;
    logic             drop;
    logic             push;
    logic             pop;

    logic [32:0]      fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    assign branch_target = word_align(branch_addr_i);

    // Every granted transaction owns a FIFO slot, so overflow cannot occur.
    assign credit_ok = ((int'(outstanding_q) + int'(fifo_count)) < int'(DEPTH))
                    && (int'(outstanding_q) < int'(MAX_OUTSTANDING));

    // Address phase: a fresh request is only raised in IDLE; once raised it
    // stays asserted with a stable address until granted.
    always_comb begin
        instr_req_o  = 1'b0;
        instr_addr_o = next_addr_q;
        unique case (state_q)
            IDLE: begin
                instr_req_o  = req_i && credit_ok;
                instr_addr_o = branch_i ? branch_target : next_addr_q;
            end
            WAIT_GNT, BRANCH_WAIT: begin
                instr_req_o  = 1'b1;
                instr_addr_o = addr_q;
            end
            default: begin
                instr_req_o  = 1'b0;
                instr_addr_o = next_addr_q;
            end
        endcase
    end

    assign gnt = instr_req_o && instr_gnt_i;

    // A grant is stale when the request it completes was issued before a
    // branch: either the branch arrives while that request is waiting, or
    // it arrived earlier and we are now in BRANCH_WAIT.
    assign stale_gnt = gnt && (((state_q == WAIT_GNT) && branch_i)
                              || (state_q == BRANCH_WAIT));

    assign drop = instr_rvalid_i && (discard_q != '0);

    // On a branch the FIFO is flushed, so nothing is pushed or popped.
    assign fetch_valid_o = !fifo_empty && !branch_i;
    assign pop           = fetch_valid_o && fetch_ready_i;
    assign push          = instr_rvalid_i && !drop && !branch_i
                        && (!fifo_full || pop);

    assign fetch_rdata_o = fifo_empty ? 32'h0 : fifo_rdata[31:0];
    assign fetch_err_o   = fifo_empty ? 1'b0  : fifo_rdata[32];

    assign busy_o = instr_req_o || (outstanding_q != '0);

    always_comb begin
        outstanding_d = outstanding_q;
        if (gnt && !instr_rvalid_i) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!gnt && instr_rvalid_i && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    // After a branch every transaction still in flight at the end of the
    // cycle is stale: the old outstanding count, plus a stale grant now,
    // minus the response that leaves this cycle (dropped by the flush).
    always_comb begin
        discard_d = discard_q;
        if (branch_i) begin
            discard_d = outstanding_q + OUT_W'(stale_gnt) - OUT_W'(instr_rvalid_i);
        end else begin
            discard_d = discard_q + OUT_W'(stale_gnt) - OUT_W'(drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            next_addr_q   <= 32'h0;
            addr_q        <= 32'h0;
            branch_addr_q <= 32'h0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            unique case (state_q)
                IDLE: begin
                    if (instr_req_o) begin
                        if (gnt) begin
                            next_addr_q <= instr_addr_o + 32'(FETCH_WORD_BYTES);
                        end else begin
                            state_q <= WAIT_GNT;
                            addr_q  <= instr_addr_o;
                        end
                    end else if (branch_i) begin
                        next_addr_q <= branch_target;
                    end
                end
                WAIT_GNT: begin
                    if (branch_i) begin
                        if (gnt) begin
                            state_q     <= IDLE;
                            next_addr_q <= branch_target;
                        end else begin
                            state_q       <= BRANCH_WAIT;
                            branch_addr_q <= branch_target;
                        end
                    end else if (gnt) begin
                        state_q     <= IDLE;
                        next_addr_q <= addr_q + 32'(FETCH_WORD_BYTES);
                    end
                end
                BRANCH_WAIT: begin
                    // A further branch replaces the remembered target.
                    if (branch_i) branch_addr_q <= branch_target;
                    if (gnt) begin
                        state_q     <= IDLE;
                        next_addr_q <= branch_i ? branch_target : branch_addr_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    cv32e40p_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({instr_err_i, instr_rdata_i}),
        .pop   (pop),
        .flush (branch_i),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_cv32e40p_fetch_fifo_ctrl.sv
module tb_cv32e40p_fetch_fifo_ctrl;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = 32'h0;
    logic        fetch_valid_o;
    logic        fetch_ready_i = 1'b0;
    logic [31:0] fetch_rdata_o;
    logic        fetch_err_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = 32'h0;
    logic        instr_err_i = 1'b0;
    logic        busy_o;

    cv32e40p_fetch_fifo_ctrl #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_ready_i  (fetch_ready_i),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_err_o    (fetch_err_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: transactions in flight (1 = stale), the words the
    // aligner should see, the bus slave's own queue of granted addresses,
    // and the address the next fresh request must carry.
    bit          inflight[$];
    logic [32:0] fifo_q[$];
    logic [31:0] slv_q[$];
    logic        pend;
    logic        pend_stale;
    logic [31:0] pend_addr;
    logic [31:0] exp_next;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        inflight.delete();
        fifo_q.delete();
        slv_q.delete();
        pend       = 1'b0;
        pend_stale = 1'b0;
        pend_addr  = 32'h0;
        exp_next   = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
        instr_err_i = 1'b0; fetch_ready_i = 1'b0;
        #3;
        check("rst_valid", fetch_valid_o, 1'b0);
        check("rst_rdata", fetch_rdata_o, 32'h0);
        check("rst_err",   fetch_err_o,   1'b0);
        check("rst_req",   instr_req_o,   1'b0);
        check("rst_addr",  instr_addr_o,  32'h0);
        check("rst_busy",  busy_o,        1'b0);
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model at the
    // falling edge, then advance the model by what the rising edge commits.
    task automatic cyc(input logic req, input logic br, input logic [31:0] ba,
                       input logic gnt, input logic rv, input logic er, input logic rdy);
        logic        rv_eff;
        logic        exp_req;
        logic        exp_valid;
        logic        stale;
        logic [31:0] exp_addr;
        logic [32:0] hd;

        rv_eff         = rv && (slv_q.size() != 0);
        req_i          = req;
        branch_i       = br;
        branch_addr_i  = ba;
        instr_gnt_i    = gnt;
        instr_rvalid_i = rv_eff;
        instr_rdata_i  = rv_eff ? data_of(slv_q[0]) : $urandom;
        instr_err_i    = rv_eff ? er : 1'b0;
        fetch_ready_i  = rdy;

        @(negedge clk);
        if (pend) begin
            exp_req  = 1'b1;
            exp_addr = pend_addr;
        end else begin
            exp_req  = req && ((inflight.size() + fifo_q.size()) < DEPTH)
                           && (inflight.size() < MAXO);
            exp_addr = br ? {ba[31:2], 2'b00} : exp_next;
        end
        exp_valid = (fifo_q.size() != 0) && !br;

        check("instr_req", instr_req_o, exp_req);
        if (exp_req) check("instr_addr", instr_addr_o, exp_addr);
        check("fetch_valid", fetch_valid_o, exp_valid);
        if (exp_valid) begin
            hd = fifo_q[0];
            check("fetch_rdata", fetch_rdata_o, hd[31:0]);
            check("fetch_err",   fetch_err_o,   hd[32]);
        end
        check("busy", busy_o, exp_req || (inflight.size() != 0));

        if (br) begin
            foreach (inflight[i]) inflight[i] = 1'b1;
            if (pend) pend_stale = 1'b1;
            exp_next = {ba[31:2], 2'b00};
        end
        if (exp_valid && rdy) void'(fifo_q.pop_front());
        if (rv_eff) begin
            stale = inflight.pop_front();
            if (!stale && !br) fifo_q.push_back({er, data_of(slv_q[0])});
            void'(slv_q.pop_front());
        end
        if (br) fifo_q.delete();
        if (exp_req && gnt) begin
            stale = pend ? pend_stale : 1'b0;
            inflight.push_back(stale);
            slv_q.push_back(instr_addr_o);
            if (!stale) exp_next = exp_addr + 32'd4;
            pend       = 1'b0;
            pend_stale = 1'b0;
        end else if (exp_req && !pend) begin
            pend       = 1'b1;
            pend_addr  = exp_addr;
            pend_stale = 1'b0;
        end

        @(posedge clk); #1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        model_clear();
        @(posedge clk); #1;
        do_reset();

        // Boot: branch to 0x83 -> fetches at 0x80, 0x84, third held until a pop.
        cyc(1, 1, 32'h0000_0083, 1, 0, 0, 0);
        cyc(1, 0, 32'h0, 1, 0, 0, 0);
        cyc(1, 0, 32'h0, 1, 1, 0, 0);
        cyc(1, 0, 32'h0, 1, 1, 0, 0);
        cyc(1, 0, 32'h0, 1, 0, 0, 0);
        cyc(1, 0, 32'h0, 1, 0, 0, 1);
        cyc(1, 0, 32'h0, 1, 0, 0, 1);
        drain(8);

        // Grant stall at 0x100 for three cycles, then 0x104.
        do_reset();
        cyc(1, 1, 32'h0000_0100, 0, 0, 0, 1);
        cyc(1, 0, 32'h0, 0, 0, 0, 1);
        cyc(1, 0, 32'h0, 0, 0, 0, 1);
        cyc(1, 0, 32'h0, 1, 0, 0, 1);
        cyc(1, 0, 32'h0, 1, 1, 0, 1);
        drain(8);

        // Branch with two outstanding (0x200, 0x204) to 0x400.
        do_reset();
        cyc(1, 1, 32'h0000_0200, 1, 0, 0, 1);
        cyc(1, 0, 32'h0, 1, 0, 0, 1);
        cyc(1, 1, 32'h0000_0400, 0, 0, 0, 1);
        cyc(1, 0, 32'h0, 1, 1, 0, 1);
        cyc(1, 0, 32'h0, 1, 1, 0, 1);
        drain(8);

        // Branch while 0x300 waits for grant, redirect to 0x500.
        do_reset();
        cyc(1, 1, 32'h0000_0300, 0, 0, 0, 1);
        cyc(1, 1, 32'h0000_0500, 0, 0, 0, 1);
        cyc(1, 0, 32'h0, 0, 0, 0, 1);
        cyc(1, 0, 32'h0, 1, 0, 0, 1);
        cyc(1, 0, 32'h0, 1, 1, 0, 1);
        drain(8);

        // Branch coincident with a response and a stale grant.
        do_reset();
        cyc(1, 1, 32'h0000_0600, 1, 0, 0, 1);
        cyc(1, 0, 32'h0, 0, 0, 0, 1);
        cyc(1, 1, 32'h0000_0700, 1, 1, 0, 1);
        cyc(1, 0, 32'h0, 1, 1, 0, 1);
        drain(8);

        // Address wrap and bus error on the first word only.
        do_reset();
        cyc(1, 1, 32'hFFFF_FFFC, 1, 0, 0, 0);
        cyc(1, 0, 32'h0, 1, 0, 0, 0);
        cyc(0, 0, 32'h0, 0, 1, 1, 0);
        cyc(0, 0, 32'h0, 0, 1, 0, 0);
        cyc(0, 0, 32'h0, 0, 0, 0, 1);
        cyc(0, 0, 32'h0, 0, 0, 0, 1);
        drain(6);

        // Randomized traffic, with a reset in the middle of it.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            cyc(1'($urandom_range(0, 9) != 0),
                1'($urandom_range(0, 19) == 0),
                $urandom,
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 4) != 0));
        end
        drain(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
